// File: rtl/packet_arbiter.sv
// packet_arbiter: round-robin merge of NUM_IN continuous AXI-stream inputs
// into one packetized output. The arbiter owns TLAST: each grant carries a
// fixed number of beats latched from packet_cycles at grant time.
// Optional build macro PACKET_ARB_STATS_EN adds pkt_count / stall_count.
module packet_arbiter #(
  parameter int DW     = 512,
  parameter int NUM_IN = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [7:0]                  packet_cycles,
  input  logic [NUM_IN*DW-1:0]        axis_in_tdata,
  input  logic [NUM_IN-1:0]           axis_in_tvalid,
  output logic [NUM_IN-1:0]           axis_in_tready,
  output logic [DW-1:0]               axis_out_tdata,
  output logic [DW/8-1:0]             axis_out_tkeep,
  output logic                        axis_out_tlast,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready,
  output logic [$clog2(NUM_IN)-1:0]   grant_id,
  output logic                        busy
`ifdef PACKET_ARB_STATS_EN
  ,
  output logic [31:0]                 pkt_count,
  output logic [31:0]                 stall_count
`endif
);

  localparam int GW = $clog2(NUM_IN);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     cycle_q, cycle_d;
  logic [7:0]     plen_q, plen_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  last_q, last_d;

  logic [GW-1:0]  winner_s;
  logic           tvalid_s;
  logic           tlast_s;
  logic           beat_s;

  // First requester strictly after 'last', wrapping around the inputs.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_IN-1:0] req,
                                            input logic [GW-1:0]     last);
    logic [GW-1:0] pick;
    logic [GW-1:0] pos;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      pos = GW'((int'(last) + k) % NUM_IN);
      if (!found && req[pos]) begin
        pick  = pos;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner_s       = rr_pick(axis_in_tvalid, last_q);
  assign axis_out_tkeep = {(DW/8){1'b1}};
  assign grant_id       = grant_q;

  // Next-state and datapath mux: arbitrate in IDLE, pass the granted stream through in SEND.
  always_comb begin
    state_d         = state_q;
    cycle_d         = cycle_q;
    plen_d          = plen_q;
    grant_d         = grant_q;
    last_d          = last_q;
    axis_in_tready  = '0;
    axis_out_tdata  = '0;
    tvalid_s        = 1'b0;
    tlast_s         = 1'b0;
    beat_s          = 1'b0;
    busy            = 1'b0;
    case (state_q)
      IDLE: begin
        if (|axis_in_tvalid) begin
          grant_d = winner_s;
          last_d  = winner_s;
          plen_d  = (packet_cycles == 8'd0) ? 8'd1 : packet_cycles;
          cycle_d = 8'd1;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        busy                    = 1'b1;
        axis_out_tdata          = axis_in_tdata[grant_q*DW +: DW];
        tvalid_s                = axis_in_tvalid[grant_q];
        axis_in_tready[grant_q] = axis_out_tready;
        tlast_s                 = (cycle_q == plen_q);
        beat_s                  = tvalid_s & axis_out_tready;
        if (beat_s) begin
          if (cycle_q == plen_q) begin
            cycle_d = 8'd1;
            state_d = IDLE;
          end else begin
            cycle_d = cycle_q + 8'd1;
          end
        end else begin
          // Source or sink stalled: hold the packet open on this stream.
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign axis_out_tvalid = tvalid_s;
  assign axis_out_tlast  = tlast_s;

  // Arbiter state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cycle_q <= 8'd1;
      plen_q  <= 8'd1;
      grant_q <= '0;
      last_q  <= GW'(NUM_IN - 1);
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      plen_q  <= plen_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef PACKET_ARB_STATS_EN
  logic [31:0] pkt_count_q;
  logic [31:0] stall_count_q;

  // Packet counter wraps; stall counter saturates so it never reads low after overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_count_q   <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (beat_s && tlast_s) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
      if ((state_q == SEND) && tvalid_s && !axis_out_tready &&
          (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed self-checking bench for packet_arbiter (NUM_IN=4, DW=32).
module tb_packet_arbiter;

  localparam int DW = 32;
  localparam int NI = 4;

  logic            clk;
  logic            resetn;
  logic [7:0]      pc;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]   in_valid;
  logic [NI-1:0]   in_ready;
  logic [DW-1:0]   out_data;
  logic [DW/8-1:0] out_keep;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef PACKET_ARB_STATS_EN
  logic [31:0]     pkt_count;
  logic [31:0]     stall_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // {busy, tvalid, tlast, grant_id, tready} followed by tdata
  logic [40:0] obs;
  assign obs = {busy, out_valid, out_last, grant_id, in_ready, out_data};

  packet_arbiter #(.DW(DW), .NUM_IN(NI)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .packet_cycles   (pc),
    .axis_in_tdata   (in_data),
    .axis_in_tvalid  (in_valid),
    .axis_in_tready  (in_ready),
    .axis_out_tdata  (out_data),
    .axis_out_tkeep  (out_keep),
    .axis_out_tlast  (out_last),
    .axis_out_tvalid (out_valid),
    .axis_out_tready (out_ready),
    .grant_id        (grant_id),
    .busy            (busy)
`ifdef PACKET_ARB_STATS_EN
    ,
    .pkt_count       (pkt_count),
    .stall_count     (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    resetn    = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    pc        = 8'd4;
    tick();
    tick();
    e = 9'b0;
    n_cmp++;
    if (obs[40:32] !== e) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", obs[40:32], e);
    end
    n_cmp++;
    if (out_keep !== 4'hF) begin
      n_err++;
      $display("FAIL reset_tkeep: got %h expected %h", out_keep, 4'hF);
    end
`ifdef PACKET_ARB_STATS_EN
    n_cmp++;
    if ({pkt_count, stall_count} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_stats: got %h/%h expected 0/0", pkt_count, stall_count);
    end
`endif
  endtask

  task automatic test_single();
    logic [40:0] e;
    do_reset();
    pc       = 8'd4;
    in_valid = 4'b0100;
    #1;
    n_cmp++;
    if (obs[40:32] !== 9'b0) begin
      n_err++;
      $display("FAIL single_idle0: got %h expected %h", obs[40:32], 9'b0);
    end
    for (int p = 0; p < 3; p++) begin
      for (int b = 1; b <= 4; b++) begin
        tick();
        e = {1'b1, 1'b1, (b == 4), 2'd2, 4'b0100, 32'hC0DE_0002};
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL single_beat p%0d b%0d: got %h expected %h", p, b, obs, e);
        end
      end
      tick();
      n_cmp++;
      if (obs[40:32] !== {3'b000, 2'd2, 4'b0000}) begin
        n_err++;
        $display("FAIL single_gap p%0d: got %h expected %h", p, obs[40:32], {3'b000, 2'd2, 4'b0000});
      end
    end
`ifdef PACKET_ARB_STATS_EN
    n_cmp++;
    if (pkt_count !== 32'd3) begin
      n_err++;
      $display("FAIL single_pkt_count: got %0d expected 3", pkt_count);
    end
`endif
  endtask

  task automatic test_round_robin();
    logic [40:0] e;
    int g;
    do_reset();
    pc       = 8'd3;
    in_valid = 4'b1111;
    #1;
    for (int p = 0; p < 5; p++) begin
      g = p % 4;
      for (int b = 1; b <= 3; b++) begin
        tick();
        e = {1'b1, 1'b1, (b == 3), 2'(g), 4'(4'b0001 << g), 32'hC0DE_0000 + 32'(g)};
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL rr_beat p%0d b%0d: got %h expected %h", p, b, obs, e);
        end
      end
      tick();
      n_cmp++;
      if (obs[40:32] !== {3'b000, 2'(g), 4'b0000}) begin
        n_err++;
        $display("FAIL rr_gap p%0d: got %h expected %h", p, obs[40:32], {3'b000, 2'(g), 4'b0000});
      end
    end
`ifdef PACKET_ARB_STATS_EN
    n_cmp++;
    if (pkt_count !== 32'd5) begin
      n_err++;
      $display("FAIL rr_pkt_count: got %0d expected 5", pkt_count);
    end
`endif
  endtask

  task automatic test_zero_len();
    logic [40:0] e;
    int g;
    do_reset();
    pc       = 8'd0;
    in_valid = 4'b1111;
    #1;
    for (int p = 0; p < 6; p++) begin
      g = p % 4;
      tick();
      e = {1'b1, 1'b1, 1'b1, 2'(g), 4'(4'b0001 << g), 32'hC0DE_0000 + 32'(g)};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL zero_len p%0d: got %h expected %h", p, obs, e);
      end
      tick();
      n_cmp++;
      if (obs[40:32] !== {3'b000, 2'(g), 4'b0000}) begin
        n_err++;
        $display("FAIL zero_gap p%0d: got %h expected %h", p, obs[40:32], {3'b000, 2'(g), 4'b0000});
      end
    end
  endtask

  task automatic test_stall();
    logic [40:0] e;
    do_reset();
    pc       = 8'd5;
    in_valid = 4'b0010;
    #1;
    for (int b = 1; b <= 2; b++) begin
      tick();
      e = {1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 32'hC0DE_0001};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL stall_pre b%0d: got %h expected %h", b, obs, e);
      end
    end
    // stream 1 goes quiet while stream 0 requests: no switch allowed
    for (int c = 0; c < 10; c++) begin
      tick();
      in_valid = 4'b0001;
      #1;
      e = {1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 32'hC0DE_0001};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL stall_hold c%0d: got %h expected %h", c, obs, e);
      end
    end
    for (int b = 3; b <= 5; b++) begin
      tick();
      in_valid = 4'b0011;
      #1;
      e = {1'b1, 1'b1, (b == 5), 2'd1, 4'b0010, 32'hC0DE_0001};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL stall_post b%0d: got %h expected %h", b, obs, e);
      end
    end
    tick();
    n_cmp++;
    if (obs[40:32] !== {3'b000, 2'd1, 4'b0000}) begin
      n_err++;
      $display("FAIL stall_gap: got %h expected %h", obs[40:32], {3'b000, 2'd1, 4'b0000});
    end
    tick();
    e = {1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 32'hC0DE_0000};
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL stall_next_grant: got %h expected %h", obs, e);
    end
`ifdef PACKET_ARB_STATS_EN
    n_cmp++;
    if ({pkt_count, stall_count} !== {32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL stall_stats: got %0d/%0d expected 1/0", pkt_count, stall_count);
    end
`endif
  endtask

  task automatic test_plen_latch();
    logic [40:0] e;
    do_reset();
    pc       = 8'd8;
    in_valid = 4'b0001;
    #1;
    for (int b = 1; b <= 8; b++) begin
      tick();
      e = {1'b1, 1'b1, (b == 8), 2'd0, 4'b0001, 32'hC0DE_0000};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL latch_first b%0d: got %h expected %h", b, obs, e);
      end
      if (b == 3) begin
        pc = 8'd2;
      end
    end
    tick();
    n_cmp++;
    if (obs[40:32] !== 9'b0) begin
      n_err++;
      $display("FAIL latch_gap: got %h expected %h", obs[40:32], 9'b0);
    end
    for (int b = 1; b <= 2; b++) begin
      tick();
      e = {1'b1, 1'b1, (b == 2), 2'd0, 4'b0001, 32'hC0DE_0000};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL latch_second b%0d: got %h expected %h", b, obs, e);
      end
    end
    tick();
    n_cmp++;
    if (obs[40:32] !== 9'b0) begin
      n_err++;
      $display("FAIL latch_gap2: got %h expected %h", obs[40:32], 9'b0);
    end
  endtask

  task automatic test_ready_reset();
    logic [40:0] e;
    logic [4:0]  pat;
    pat = 5'b01001;
    do_reset();
    pc       = 8'd4;
    in_valid = 4'b0100;
    #1;
    // ready pattern accepts beats 1 and 2 only: cycle counter never reaches 4
    for (int c = 0; c < 5; c++) begin
      tick();
      out_ready = pat[c];
      #1;
      e = {1'b1, 1'b1, 1'b0, 2'd2, (pat[c] ? 4'b0100 : 4'b0000), 32'hC0DE_0002};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL ready_toggle c%0d: got %h expected %h", c, obs, e);
      end
    end
`ifdef PACKET_ARB_STATS_EN
    n_cmp++;
    if ({pkt_count, stall_count} !== {32'd0, 32'd2}) begin
      n_err++;
      $display("FAIL ready_stats: got %0d/%0d expected 0/2", pkt_count, stall_count);
    end
`endif
    resetn    = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (obs[40:32] !== 9'b0) begin
      n_err++;
      $display("FAIL midreset_state: got %h expected %h", obs[40:32], 9'b0);
    end
`ifdef PACKET_ARB_STATS_EN
    n_cmp++;
    if ({pkt_count, stall_count} !== 64'd0) begin
      n_err++;
      $display("FAIL midreset_stats: got %0d/%0d expected 0/0", pkt_count, stall_count);
    end
`endif
    resetn = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      tick();
      e = {1'b1, 1'b1, (b == 4), 2'd0, 4'b0001, 32'hC0DE_0000};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL after_reset b%0d: got %h expected %h", b, obs, e);
      end
    end
    tick();
    n_cmp++;
    if (obs[40:32] !== 9'b0) begin
      n_err++;
      $display("FAIL after_reset_gap: got %h expected %h", obs[40:32], 9'b0);
    end
`ifdef PACKET_ARB_STATS_EN
    n_cmp++;
    if (pkt_count !== 32'd1) begin
      n_err++;
      $display("FAIL after_reset_pkt: got %0d expected 1", pkt_count);
    end
`endif
  endtask

  initial begin
    resetn    = 1'b0;
    pc        = 8'd0;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_data[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_stall();
    test_plen_latch();
    test_ready_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
